// File: rtl/scr1_tcm_portb_arb.sv
// scr1_tcm_portb_arb: core/boot-loader arbiter for TCM port B; SCR1_TCM_ARB_RR_EN selects round-robin instead of loader priority with burst limit
module scr1_tcm_portb_arb #(
  parameter int SCR1_AWIDTH   = 16,
  parameter int SCR1_LD_BURST = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   core_req,
  input  logic                   core_we,
  input  logic [3:0]             core_be,
  input  logic [SCR1_AWIDTH-3:0] core_addr,
  input  logic [31:0]            core_wdata,
  output logic                   core_ack,
  output logic                   core_rvalid,
  output logic [31:0]            core_rdata,
  input  logic                   ld_req,
  input  logic                   ld_we,
  input  logic [3:0]             ld_be,
  input  logic [SCR1_AWIDTH-3:0] ld_addr,
  input  logic [31:0]            ld_wdata,
  output logic                   ld_ack,
  output logic                   ld_rvalid,
  output logic [31:0]            ld_rdata,
  input  logic                   boot_hold,
  output logic                   renb,
  output logic                   wenb,
  output logic [3:0]             webb,
  output logic [SCR1_AWIDTH-3:0] addrb,
  output logic [31:0]            datab,
  input  logic [31:0]            qb
);
  typedef enum logic [1:0] {IDLE, CORE, LOAD} state_t;
  state_t                 state;
  logic                   rd_q;
  logic [SCR1_AWIDTH-3:0] addr_q;
  logic [31:0]            data_q;
  logic                   core_el;
  logic                   core_turn;
  logic                   ld_win;
  logic                   core_win;
  logic                   any_win;
  logic                   win_we;
  logic [3:0]             win_be;
  logic [SCR1_AWIDTH-3:0] win_addr;
  logic [31:0]            win_data;
  assign core_el = core_req & ~boot_hold;
`ifdef SCR1_TCM_ARB_RR_EN
  logic last_core;
  assign core_turn = ~last_core;
  // remember which requester was served most recently; loader goes first out of reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_core <= 1'b1;
    else if (any_win) last_core <= core_win;
`else
  localparam int CW = $clog2(SCR1_LD_BURST + 1);
  logic [CW-1:0] cnt;
  assign core_turn = cnt == CW'(SCR1_LD_BURST);
  // loader grants taken while the core waits; saturates at the burst limit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (!core_req || core_win) cnt <= '0;
    else if (ld_win && !boot_hold && !core_turn) cnt <= cnt + CW'(1);
`endif
  assign ld_win   = rst_n & ld_req & ~(core_el & core_turn);
  assign core_win = rst_n & core_el & ~ld_win;
  assign any_win  = ld_win | core_win;
  assign core_ack = core_win;
  assign ld_ack   = ld_win;
  // winner's request fields steer port B
  always_comb begin
    win_we   = ld_win ? ld_we    : core_we;
    win_be   = ld_win ? ld_be    : core_be;
    win_addr = ld_win ? ld_addr  : core_addr;
    win_data = ld_win ? ld_wdata : core_wdata;
    renb     = any_win & ~win_we;
    wenb     = any_win & win_we;
    webb     = wenb ? win_be : 4'b0000;
    addrb    = any_win ? win_addr : addr_q;
    datab    = any_win ? win_data : data_q;
  end
  // owner tag (state) and read flag for the response one cycle behind the grant
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      rd_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state <= core_win ? CORE : ld_win ? LOAD : IDLE;
      rd_q  <= any_win & ~win_we;
      if (any_win) begin
        addr_q <= win_addr;
        data_q <= win_data;
      end
    end
  assign core_rvalid = state == CORE;
  assign ld_rvalid   = state == LOAD;
  assign core_rdata  = (core_rvalid && rd_q) ? qb : 32'h0;
  assign ld_rdata    = (ld_rvalid && rd_q) ? qb : 32'h0;
endmodule

// File: tb/tb_scr1_tcm_portb_arb.sv
// tb_scr1_tcm_portb_arb: randomized and directed scoreboard bench for the TCM port B arbiter
module tb_scr1_tcm_portb_arb;
  localparam int LDB = 8;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        core_req = 0, core_we = 0, ld_req = 0, ld_we = 0, boot_hold = 0;
  logic [3:0]  core_be = 0, ld_be = 0;
  logic [13:0] core_addr = 0, ld_addr = 0;
  logic [31:0] core_wdata = 0, ld_wdata = 0;
  logic        core_ack, core_rvalid, ld_ack, ld_rvalid, renb, wenb;
  logic [31:0] core_rdata, ld_rdata, datab;
  logic [31:0] qb = 0;
  logic [3:0]  webb;
  logic [13:0] addrb;
  scr1_tcm_portb_arb #(.SCR1_AWIDTH(16), .SCR1_LD_BURST(LDB)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_be(core_be), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_be(ld_be), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .boot_hold(boot_hold),
    .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab), .qb(qb)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  // TCM port B: synchronous read, byte-enabled write
  logic [31:0] mem [16] = '{default: 32'h0};
  always @(posedge clk) begin
    if (renb) qb <= mem[addrb[3:0]];
    if (wenb) for (int b = 0; b < 4; b++) if (webb[b]) mem[addrb[3:0]][8*b +: 8] <= datab[8*b +: 8];
  end
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask
  typedef struct {bit core; logic [31:0] data; int stamp;} exp_t;
  exp_t sb[$];
  exp_t e;
  // reference model: who should win, what port B shows, what each response returns
  logic [31:0] gold [16] = '{default: 32'h0};
  int          streak = 0;
  bit          last_core = 1;
  logic [13:0] last_addr = 0, m_a;
  logic [31:0] last_data = 0, m_d;
  logic [3:0]  m_be;
  bit          c_el, c_turn, wl, wc, m_we;
  always @(negedge clk) begin
    if (!rst_n) begin
      streak = 0;
      last_core = 1;
      last_addr = 0;
      last_data = 0;
    end else begin
      c_el = core_req && !boot_hold;
`ifdef SCR1_TCM_ARB_RR_EN
      c_turn = !last_core;
`else
      c_turn = streak >= LDB;
`endif
      wl = ld_req && !(c_el && c_turn);
      wc = c_el && !wl;
      chk("core_ack", core_ack, wc);
      chk("ld_ack", ld_ack, wl);
      if (wl || wc) begin
        m_we = wl ? ld_we : core_we;
        m_be = wl ? ld_be : core_be;
        m_a  = wl ? ld_addr : core_addr;
        m_d  = wl ? ld_wdata : core_wdata;
        chk("portb", {renb, wenb, webb, addrb, datab}, {!m_we, m_we, m_we ? m_be : 4'h0, m_a, m_d});
        sb.push_back(exp_t'{wc, m_we ? 32'h0 : gold[m_a[3:0]], cyc});
        if (m_we) for (int b = 0; b < 4; b++) if (m_be[b]) gold[m_a[3:0]][8*b +: 8] = m_d[8*b +: 8];
        last_addr = m_a;
        last_data = m_d;
        last_core = wc;
      end else chk("portb_idle", {renb, wenb, webb, addrb, datab}, {2'b00, 4'h0, last_addr, last_data});
      streak = (!core_req || wc) ? 0 : (wl && !boot_hold) ? streak + 1 : streak;
    end
  end
  // monitor: every rvalid must match the oldest outstanding grant, one cycle late
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      chk("rst_rvalid", {core_rvalid, ld_rvalid}, 2'b00);
    end else begin
      chk("rvalid_excl", core_rvalid && ld_rvalid, 1'b0);
      if (core_rvalid || ld_rvalid) begin
        if (sb.size() == 0) chk("unexpected_rvalid", 1'b1, 1'b0);
        else begin
          e = sb.pop_front();
          chk("resp", {core_rvalid, e.stamp == cyc - 1, core_rdata, ld_rdata},
              {e.core, 1'b1, e.core ? e.data : 32'h0, e.core ? 32'h0 : e.data});
        end
      end else if (sb.size() > 0 && sb[0].stamp == cyc - 1) begin
        chk("missing_rvalid", 1'b0, 1'b1);
        void'(sb.pop_front());
      end
    end
  end
  task automatic tick(output logic ca, output logic la, output logic cv, output logic [31:0] cd);
    @(negedge clk);
    ca = core_ack;
    la = ld_ack;
    cv = core_rvalid;
    cd = core_rdata;
    @(posedge clk);
    #1;
  endtask
  task automatic set_core(input logic r, input logic w, input logic [3:0] be, input logic [13:0] a, input logic [31:0] d);
    core_req = r; core_we = w; core_be = be; core_addr = a; core_wdata = d;
  endtask
  task automatic set_ld(input logic r, input logic w, input logic [3:0] be, input logic [13:0] a, input logic [31:0] d);
    ld_req = r; ld_we = w; ld_be = be; ld_addr = a; ld_wdata = d;
  endtask
  function automatic logic [127:0] all_outs();
    return 128'({renb, wenb, webb, addrb, datab, core_ack, ld_ack, core_rvalid, ld_rvalid, core_rdata, ld_rdata});
  endfunction
  logic ca, la, cv, pca;
  logic [31:0] cd;
  int lcnt, ccnt, idle;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 128'h0);
    rst_n = 1;
    // loader writes boot word, core reads it back
    set_ld(1, 1, 4'hF, 14'd0, 32'h01402603);
    tick(ca, la, cv, cd);
    chk("boot_wr_ack", la, 1'b1);
    set_ld(0, 0, 4'h0, 14'd0, 32'h0);
    set_core(1, 0, 4'hF, 14'd0, 32'h0);
    tick(ca, la, cv, cd);
    chk("boot_rd_ack", ca, 1'b1);
    set_core(0, 0, 4'h0, 14'd0, 32'h0);
    tick(ca, la, cv, cd);
    chk("boot_rd_data", {cv, cd}, {1'b1, 32'h01402603});
    // boot_hold blocks the core for 20 cycles
    boot_hold = 1;
    set_core(1, 0, 4'hF, 14'd1, 32'h0);
    set_ld(1, 0, 4'hF, 14'd2, 32'h0);
    lcnt = 0; ccnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(ca, la, cv, cd);
      lcnt += int'(la);
      ccnt += int'(ca);
    end
    chk("hold_ld_acks", lcnt, 20);
    chk("hold_core_acks", ccnt, 0);
    boot_hold = 0;
    set_ld(0, 0, 4'h0, 14'd0, 32'h0);
    tick(ca, la, cv, cd);
    chk("hold_release_ack", ca, 1'b1);
    set_core(0, 0, 4'h0, 14'd0, 32'h0);
    tick(ca, la, cv, cd);
    // both requesting continuously: burst pattern (or alternation in round-robin)
    set_core(1, 0, 4'hF, 14'd1, 32'h0);
    set_ld(1, 0, 4'hF, 14'd2, 32'h0);
    idle = 0; ccnt = 0; pca = 0;
    for (int i = 0; i < 27; i++) begin
      tick(ca, la, cv, cd);
      if (!ca && !la) idle++;
      ccnt += int'(ca);
`ifdef SCR1_TCM_ARB_RR_EN
      if (i > 0) chk("rr_alternate", ca, !pca);
`else
      chk("burst_pattern", ca, 1'((i % 9) == 8));
`endif
      pca = ca;
    end
    chk("no_idle", idle, 0);
`ifndef SCR1_TCM_ARB_RR_EN
    chk("burst_core_grants", ccnt, 3);
`endif
    set_core(0, 0, 4'h0, 14'd0, 32'h0);
    set_ld(0, 0, 4'h0, 14'd0, 32'h0);
    tick(ca, la, cv, cd);
    // byte-lane write merge
    set_ld(1, 1, 4'hF, 14'd3, 32'h11223344);
    tick(ca, la, cv, cd);
    set_ld(1, 1, 4'b0100, 14'd3, 32'hAABBCCDD);
    tick(ca, la, cv, cd);
    set_ld(0, 0, 4'h0, 14'd0, 32'h0);
    set_core(1, 0, 4'hF, 14'd3, 32'h0);
    tick(ca, la, cv, cd);
    set_core(0, 0, 4'h0, 14'd0, 32'h0);
    tick(ca, la, cv, cd);
    chk("byte_merge", {cv, cd}, {1'b1, 32'h11BB3344});
    // reset right after a core read grant discards the response
    set_core(1, 0, 4'hF, 14'd0, 32'h0);
    tick(ca, la, cv, cd);
    chk("pre_rst_ack", ca, 1'b1);
    rst_n = 0;
    #1;
    chk("mid_rst_outputs", all_outs(), 128'h0);
    tick(ca, la, cv, cd);
    chk("rst_core_rvalid", cv, 1'b0);
    set_core(0, 0, 4'h0, 14'd0, 32'h0);
    rst_n = 1;
    tick(ca, la, cv, cd);
    chk("post_rst_rvalid", cv, 1'b0);
    // randomized traffic, requests held until acknowledged
    for (int i = 0; i < 400; i++) begin
      tick(ca, la, cv, cd);
      if (ca || !core_req)
        set_core(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), 14'($urandom_range(0, 15)), $urandom);
      if (la || !ld_req)
        set_ld(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 4'($urandom), 14'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 15) == 0) boot_hold = !boot_hold;
    end
    set_core(0, 0, 4'h0, 14'd0, 32'h0);
    set_ld(0, 0, 4'h0, 14'd0, 32'h0);
    boot_hold = 0;
    repeat (3) tick(ca, la, cv, cd);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
